ff_bank: RTL and testbench

Parametrised bank of WIDTH independent flip-flop channels, the next generation of the single-bit SR flip-flop. All channels share one runtime-selectable behaviour: SR, JK, D or T. The SR-illegal input combination is resolved by a compile-time policy, and every occurrence is recorded in per-channel sticky error flags and a saturating event counter. The bank sits wherever the design needs a group of control/status bits with a configurable update rule, plus a parallel preload.

---
 rtl/ff_bank_pkg.sv | 17 +
 rtl/ff_cell.sv | 104 ++++++++++
 rtl/ff_bank.sv | 97 +++++++++
 tb/tb_ff_bank.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/ff_bank_pkg.sv
// ff_bank_pkg: shared encodings for the flip-flop bank.
//   - mode_e      : runtime update rule shared by all channels (SR, JK, D, T)
//   - POL_*       : compile-time resolution of the SR=11 input combination
package ff_bank_pkg;

    typedef enum logic [1:0] {
        MODE_SR = 2'b00,
        MODE_JK = 2'b01,
        MODE_D  = 2'b10,
        MODE_T  = 2'b11
    } mode_e;

    localparam int POL_HOLD = 0;
    localparam int POL_SET  = 1;
    localparam int POL_RST  = 2;

endpackage

// File: rtl/ff_cell.sv
// ff_cell: one channel of the flip-flop bank.
// Holds the channel state flop and its sticky SR-illegal flag, and reports
// whether the current inputs form an illegal SR event this cycle.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-low reset
//   en       update enable
//   ld       parallel load strobe (beats en)
//   ld_val   value loaded when ld=1
//   mode     shared update rule
//   ctl      {S,R} / {J,K} / {-,D} / {-,T}
//   clr_err  clear the sticky error flag
//   q        channel state
//   err      sticky illegal flag
//   illegal  combinational: this channel is SR=11 with en=1, ld=0 this cycle
module ff_cell
    import ff_bank_pkg::*;
#(
    parameter int SR_POLICY = POL_HOLD
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       ld,
    input  logic       ld_val,
    input  logic [1:0] mode,
    input  logic [1:0] ctl,
    input  logic       clr_err,
    output logic       q,
    output logic       err,
    output logic       illegal
);

    logic q_reg;
    logic q_next;
    logic err_reg;
    logic err_next;

    always_comb begin
        q_next  = q_reg;
        illegal = 1'b0;
        if (ld) begin
            q_next = ld_val;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_SR: begin
                    case (ctl)
                        2'b10: q_next = 1'b1;
                        2'b01: q_next = 1'b0;
                        2'b11: begin
                            illegal = 1'b1;
                            if (SR_POLICY == POL_SET) begin
                                q_next = 1'b1;
                            end else if (SR_POLICY == POL_RST) begin
                                q_next = 1'b0;
                            end
                        end
                        default: q_next = q_reg;
                    endcase
                end
                MODE_JK: begin
                    case (ctl)
                        2'b10:   q_next = 1'b1;
                        2'b01:   q_next = 1'b0;
                        2'b11:   q_next = ~q_reg;
                        default: q_next = q_reg;
                    endcase
                end
                MODE_D: q_next = ctl[0];
                MODE_T: begin
                    if (ctl[0]) begin
                        q_next = ~q_reg;
                    end
                end
                default: q_next = q_reg;
            endcase
        end
    end

    // A new illegal event beats a concurrent clear, so after clr_err the flag
    // reflects only the channels that were illegal in that same cycle.
    always_comb begin
        err_next = err_reg;
        if (illegal) begin
            err_next = 1'b1;
        end else if (clr_err) begin
            err_next = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            q_reg   <= 1'b0;
            err_reg <= 1'b0;
        end else begin
            q_reg   <= q_next;
            err_reg <= err_next;
        end
    end

    assign q   = q_reg;
    assign err = err_reg;

endmodule

// File: rtl/ff_bank.sv
// ff_bank: WIDTH independent flip-flop channels sharing one runtime update
// rule (SR / JK / D / T), with parallel preload, sticky per-channel SR-illegal
// flags and a saturating count of cycles containing any illegal channel.
// Ports:
//   clk      clock, rising edge
//   rst      synchronous active-low reset
//   en       global update enable
//   mode     00 SR, 01 JK, 10 D, 11 T
//   ctl      channel i uses ctl[2i+1:2i]
//   ld       parallel load strobe
//   ld_val   parallel load value
//   clr_err  clear err and err_cnt
//   q        channel states
//   qb       combinational ~q
//   err      sticky per-channel illegal flags
//   err_cnt  saturating illegal-cycle counter
module ff_bank
    import ff_bank_pkg::*;
#(
    parameter int WIDTH     = 8,
    parameter int CNT_W     = 8,
    parameter int SR_POLICY = POL_HOLD
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 en,
    input  logic [1:0]           mode,
    input  logic [2*WIDTH-1:0]   ctl,
    input  logic                 ld,
    input  logic [WIDTH-1:0]     ld_val,
    input  logic                 clr_err,
    output logic [WIDTH-1:0]     q,
    output logic [WIDTH-1:0]     qb,
    output logic [WIDTH-1:0]     err,
    output logic [CNT_W-1:0]     err_cnt
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [WIDTH-1:0] cell_q;
    logic [WIDTH-1:0] cell_err;
    logic [WIDTH-1:0] cell_illegal;
    logic             any_illegal;
    logic [CNT_W-1:0] cnt_reg;
    logic [CNT_W-1:0] cnt_next;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_cell
            ff_cell #(
                .SR_POLICY(SR_POLICY)
            ) u_cell (
                .clk     (clk),
                .rst     (rst),
                .en      (en),
                .ld      (ld),
                .ld_val  (ld_val[gi]),
                .mode    (mode),
                .ctl     (ctl[2*gi+1:2*gi]),
                .clr_err (clr_err),
                .q       (cell_q[gi]),
                .err     (cell_err[gi]),
                .illegal (cell_illegal[gi])
            );
        end
    endgenerate

    // One count per cycle no matter how many channels were illegal.
    assign any_illegal = |cell_illegal;

    always_comb begin
        cnt_next = cnt_reg;
        if (any_illegal) begin
            if (clr_err) begin
                cnt_next = CNT_ONE;
            end else if (cnt_reg != CNT_MAX) begin
                cnt_next = cnt_reg + CNT_ONE;
            end
        end else if (clr_err) begin
            cnt_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign q       = cell_q;
    assign qb      = ~cell_q;
    assign err     = cell_err;
    assign err_cnt = cnt_reg;

endmodule

// File: tb/tb_ff_bank.sv
// tb_ff_bank: three ff_bank instances (SR_POLICY hold/set/reset; the last two
// with a 2-bit counter to reach saturation) driven by the same directed
// vectors. A behavioural model is compared against every instance on each
// falling edge; literal checks pin the expected values at key points.
module tb_ff_bank;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic        ld = 1'b0;
    logic        clr_err = 1'b0;
    logic [1:0]  mode = 2'b00;
    logic [15:0] ctl = 16'h0000;
    logic [7:0]  ld_val = 8'h00;

    logic [7:0] q0, qb0, err0, cnt0;
    logic [7:0] q1, qb1, err1;
    logic [7:0] q2, qb2, err2;
    logic [1:0] cnt1, cnt2;

    logic [7:0] dq[3];
    logic [7:0] dqb[3];
    logic [7:0] derr[3];
    logic [7:0] dcnt[3];

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    ff_bank #(.WIDTH(8), .CNT_W(8), .SR_POLICY(0)) dut0 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .ctl(ctl), .ld(ld),
        .ld_val(ld_val), .clr_err(clr_err), .q(q0), .qb(qb0), .err(err0),
        .err_cnt(cnt0));
    ff_bank #(.WIDTH(8), .CNT_W(2), .SR_POLICY(1)) dut1 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .ctl(ctl), .ld(ld),
        .ld_val(ld_val), .clr_err(clr_err), .q(q1), .qb(qb1), .err(err1),
        .err_cnt(cnt1));
    ff_bank #(.WIDTH(8), .CNT_W(2), .SR_POLICY(2)) dut2 (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .ctl(ctl), .ld(ld),
        .ld_val(ld_val), .clr_err(clr_err), .q(q2), .qb(qb2), .err(err2),
        .err_cnt(cnt2));

    assign dq[0] = q0;   assign dqb[0] = qb0; assign derr[0] = err0; assign dcnt[0] = cnt0;
    assign dq[1] = q1;   assign dqb[1] = qb1; assign derr[1] = err1; assign dcnt[1] = {6'b0, cnt1};
    assign dq[2] = q2;   assign dqb[2] = qb2; assign derr[2] = err2; assign dcnt[2] = {6'b0, cnt2};

    // ---------------- behavioural model ----------------
    int         pol[3]  = '{0, 1, 2};
    int         cmax[3] = '{255, 3, 3};
    logic [7:0] mq[3];
    logic [7:0] merr[3];
    int         mcnt[3];
    bit         model_valid = 1'b0;
    logic [7:0] m_nq;
    logic [7:0] m_ill;
    bit         m_s, m_r;

    always @(posedge clk) begin
        for (int d = 0; d < 3; d++) begin
            if (!rst) begin
                mq[d] = 8'h00; merr[d] = 8'h00; mcnt[d] = 0;
            end else begin
                m_nq  = mq[d];
                m_ill = 8'h00;
                for (int ch = 0; ch < 8; ch++) begin
                    m_s = ctl[2*ch+1];
                    m_r = ctl[2*ch];
                    if (ld) begin
                        m_nq[ch] = ld_val[ch];
                    end else if (en) begin
                        if (mode == 2'd0) begin
                            if (m_s && !m_r)      m_nq[ch] = 1'b1;
                            else if (!m_s && m_r) m_nq[ch] = 1'b0;
                            else if (m_s && m_r) begin
                                m_ill[ch] = 1'b1;
                                if (pol[d] == 1)      m_nq[ch] = 1'b1;
                                else if (pol[d] == 2) m_nq[ch] = 1'b0;
                            end
                        end else if (mode == 2'd1) begin
                            if (m_s && !m_r)      m_nq[ch] = 1'b1;
                            else if (!m_s && m_r) m_nq[ch] = 1'b0;
                            else if (m_s && m_r)  m_nq[ch] = ~mq[d][ch];
                        end else if (mode == 2'd2) begin
                            m_nq[ch] = m_r;
                        end else begin
                            if (m_r) m_nq[ch] = ~mq[d][ch];
                        end
                    end
                end
                mq[d] = m_nq;
                if (m_ill != 8'h00) begin
                    merr[d] = (clr_err ? 8'h00 : merr[d]) | m_ill;
                    mcnt[d] = clr_err ? 1 : ((mcnt[d] < cmax[d]) ? mcnt[d] + 1 : cmax[d]);
                end else if (clr_err) begin
                    merr[d] = 8'h00;
                    mcnt[d] = 0;
                end
            end
        end
        if (!rst) model_valid = 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (model_valid) begin
            for (int d = 0; d < 3; d++) begin
                chk($sformatf("dut%0d.q", d),       {24'b0, dq[d]},   {24'b0, mq[d]});
                chk($sformatf("dut%0d.qb", d),      {24'b0, dqb[d]},  {24'b0, ~mq[d]});
                chk($sformatf("dut%0d.err", d),     {24'b0, derr[d]}, {24'b0, merr[d]});
                chk($sformatf("dut%0d.err_cnt", d), {24'b0, dcnt[d]}, mcnt[d]);
            end
        end
    end

    task automatic step(input logic r, input logic e, input logic [1:0] m,
                        input logic [15:0] c, input logic l, input logic [7:0] lv,
                        input logic ce, input string tag);
        rst = r; en = e; mode = m; ctl = c; ld = l; ld_val = lv; clr_err = ce;
        @(posedge clk);
        #1;
        $display("step %-10s rst=%b en=%b mode=%0d ctl=%h ld=%b ld_val=%h clr=%b | q=%h/%h/%h err=%h cnt=%0d/%0d/%0d",
                 tag, r, e, m, c, l, lv, ce, q0, q1, q2, err0, cnt0, cnt1, cnt2);
    endtask

    initial begin
        // Reset with a competing load
        step(0, 0, 2'd0, 16'h0000, 1, 8'hFF, 0, "reset");
        step(0, 0, 2'd0, 16'h0000, 1, 8'hFF, 0, "reset");
        chk("rst_q", q0, 8'h00);
        chk("rst_qb", qb0, 8'hFF);
        chk("rst_err", err0, 8'h00);
        chk("rst_cnt", cnt0, 8'h00);
        step(1, 0, 2'd0, 16'h0000, 1, 8'hA5, 0, "load");
        chk("load_q", q0, 8'hA5);

        // SR sequence on channel 0
        step(1, 1, 2'd0, 16'h0001, 0, 8'h00, 0, "sr01");
        chk("sr01_q", q0, 8'hA4);
        step(1, 1, 2'd0, 16'h0002, 0, 8'h00, 0, "sr10");
        chk("sr10_q", q0, 8'hA5);
        step(1, 1, 2'd0, 16'h0003, 0, 8'h00, 0, "sr11");
        chk("sr11_q_hold", q0, 8'hA5);
        chk("sr11_q_set", q1, 8'hA5);
        chk("sr11_q_rst", q2, 8'hA4);
        chk("sr11_err", err0, 8'h01);
        chk("sr11_cnt", cnt0, 8'h01);
        step(1, 1, 2'd0, 16'h0000, 0, 8'h00, 0, "sr00");
        chk("sr00_q_rst", q2, 8'hA4);

        // Clear with no event
        step(1, 0, 2'd0, 16'h0000, 0, 8'h00, 1, "clr");
        chk("clr_err", err0, 8'h00);
        chk("clr_cnt", cnt0, 8'h00);

        // JK toggling
        step(1, 1, 2'd0, 16'h0000, 1, 8'h00, 0, "load0");
        step(1, 1, 2'd1, 16'hFFFF, 0, 8'h00, 0, "jk11");
        chk("jk1_q", q0, 8'hFF);
        step(1, 1, 2'd1, 16'hFFFF, 0, 8'h00, 0, "jk11");
        chk("jk2_q", q0, 8'h00);
        step(1, 1, 2'd1, 16'hFFFF, 0, 8'h00, 0, "jk11");
        chk("jk3_q", q0, 8'hFF);
        chk("jk_err", err0, 8'h00);

        // T mode on even channels
        step(1, 1, 2'd0, 16'h0000, 1, 8'h00, 0, "load0");
        step(1, 1, 2'd3, 16'h1111, 0, 8'h00, 0, "t_even");
        chk("t_q", q0, 8'h55);

        // Counter saturation with every channel SR=11
        for (int k = 0; k < 5; k++) begin
            step(1, 1, 2'd0, 16'hFFFF, 0, 8'h00, 0, "sr_all11");
            chk("sat_cnt1", {6'b0, cnt1}, (k < 3) ? k + 1 : 3);
            chk("sat_cnt0", cnt0, 8'(k + 1));
        end
        chk("sat_err", err1, 8'hFF);
        chk("sat_q_set", q1, 8'hFF);
        chk("sat_q_rst", q2, 8'h00);

        // Clear concurrent with channel 3 illegal
        step(1, 1, 2'd0, 16'h00C0, 0, 8'h00, 1, "clr+ill3");
        chk("clrill_err", err1, 8'h08);
        chk("clrill_cnt", {6'b0, cnt1}, 32'd1);
        chk("clrill_q", q0, 8'h55);

        // Enable low ignores ctl
        step(1, 0, 2'd1, 16'h1234, 0, 8'h00, 0, "en0");
        chk("en0_q", q0, 8'h55);

        // Load beats SR=11 and raises no event
        step(1, 1, 2'd0, 16'hFFFF, 1, 8'h5A, 0, "ld+sr11");
        chk("ldpri_q", q2, 8'h5A);
        chk("ldpri_err", err0, 8'h08);
        chk("ldpri_cnt", cnt0, 8'h01);

        // D mode then switch to SR hold
        step(1, 1, 2'd2, 16'hAFFA, 0, 8'h00, 0, "d3c");
        chk("d_q", q0, 8'h3C);
        step(1, 1, 2'd0, 16'h0000, 0, 8'h00, 0, "sr_hold");
        chk("sw_q", q0, 8'h3C);
        chk("sw_qb", qb0, 8'hC3);

        // Reset mid-operation discards load and illegal events
        step(0, 1, 2'd0, 16'hFFFF, 1, 8'hFF, 0, "rst_mid");
        chk("rstmid_q", q1, 8'h00);
        chk("rstmid_err", err1, 8'h00);
        chk("rstmid_cnt", {6'b0, cnt1}, 32'd0);
        step(1, 1, 2'd2, 16'h0001, 0, 8'h00, 0, "d_after");
        chk("after_q", q0, 8'h01);

        @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
